// File: rtl/sextium_pkg.sv
// Shared types and constants for the sextium memory bridge: FSM state encoding,
// operation encoding and default timing.
package sextium_pkg;

  localparam int CNT_W = 4;

  localparam int DEF_READ_WAIT  = 2;
  localparam int DEF_WRITE_WAIT = 2;
  localparam int DEF_TURNAROUND = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ACK    = 3'd3,
    ST_TURN   = 3'd4
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Counter load value for the ACCESS phase of a given operation.
  function automatic logic [CNT_W-1:0] access_load(input op_e op,
                                                   input logic [CNT_W-1:0] rd_wait,
                                                   input logic [CNT_W-1:0] wr_wait);
    return (op == OP_WRITE) ? wr_wait : rd_wait;
  endfunction

endpackage

// File: rtl/sextium_wait_counter.sv
// 4-bit loadable down-counter that saturates at zero; times both the ACCESS
// and TURN phases of the bridge.
module sextium_wait_counter
  import sextium_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sextium_mem_bridge.sv
// Bridges the sextium core level handshake to an asynchronous SRAM with
// programmable read/write wait states and a post-access turnaround gap.
module sextium_mem_bridge
  import sextium_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int READ_WAIT  = DEF_READ_WAIT,
  parameter int WRITE_WAIT = DEF_WRITE_WAIT,
  parameter int TURNAROUND = DEF_TURNAROUND
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [ADDR_WIDTH-1:0] i_addr_bus,
  input  logic [DATA_WIDTH-1:0] i_mem_bus_out,
  output logic [DATA_WIDTH-1:0] o_mem_bus_in,
  output logic                  o_mem_ack,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_dq_out,
  output logic                  o_sram_dq_oe,
  input  logic [DATA_WIDTH-1:0] i_sram_dq_in,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n,
  output logic                  o_proto_err
);

  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WRITE_WAIT);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURNAROUND - 1);

  state_e                r_state;
  op_e                   r_op;
  logic [DATA_WIDTH-1:0] r_mem_bus_in;
  logic                  r_mem_ack;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [DATA_WIDTH-1:0] r_sram_dq_out;
  logic                  r_sram_dq_oe;
  logic                  r_sram_ce_n;
  logic                  r_sram_oe_n;
  logic                  r_sram_we_n;
  logic                  r_proto_err;

  logic                  w_cnt_load;
  logic [CNT_W-1:0]      w_cnt_val;
  logic                  w_cnt_dec;
  logic                  w_cnt_zero;

  // Counter is reloaded on the way into ACCESS and on the way into TURN.
  assign w_cnt_load = (r_state == ST_SETUP) || (r_state == ST_ACK);
  assign w_cnt_val  = (r_state == ST_ACK) ? TURN_LOAD : access_load(r_op, RD_LOAD, WR_LOAD);
  assign w_cnt_dec  = ((r_state == ST_ACCESS) || (r_state == ST_TURN)) && !w_cnt_zero;

  sextium_wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_READ;
      r_mem_bus_in  <= '0;
      r_mem_ack     <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
      r_sram_ce_n   <= 1'b1;
      r_sram_oe_n   <= 1'b1;
      r_sram_we_n   <= 1'b1;
      r_proto_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_mem_read || i_mem_write) begin
            r_sram_addr   <= i_addr_bus;
            r_sram_dq_out <= i_mem_bus_out;
            r_op          <= i_mem_write ? OP_WRITE : OP_READ;
            r_sram_ce_n   <= 1'b0;
            r_sram_dq_oe  <= i_mem_write;
            r_state       <= ST_SETUP;
            if (i_mem_read && i_mem_write) begin
              r_proto_err <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          r_sram_oe_n <= (r_op == OP_WRITE);
          r_sram_we_n <= (r_op == OP_READ);
          r_state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_cnt_zero) begin
            r_sram_oe_n <= 1'b1;
            r_sram_we_n <= 1'b1;
            r_mem_ack   <= 1'b1;
            if (r_op == OP_READ) begin
              r_mem_bus_in <= i_sram_dq_in;
            end
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          // Write data stays driven through ACK to cover hold after we_n rises.
          r_mem_ack    <= 1'b0;
          r_sram_ce_n  <= 1'b1;
          r_sram_dq_oe <= 1'b0;
          r_state      <= ST_TURN;
        end
        ST_TURN: begin
          if (w_cnt_zero) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_mem_bus_in  = r_mem_bus_in;
  assign o_mem_ack     = r_mem_ack;
  assign o_sram_addr   = r_sram_addr;
  assign o_sram_dq_out = r_sram_dq_out;
  assign o_sram_dq_oe  = r_sram_dq_oe;
  assign o_sram_ce_n   = r_sram_ce_n;
  assign o_sram_oe_n   = r_sram_oe_n;
  assign o_sram_we_n   = r_sram_we_n;
  assign o_proto_err   = r_proto_err;

endmodule

// File: tb/tb_sextium_mem_bridge.sv
// Randomized self-checking bench for sextium_mem_bridge against a cycle-timeline
// reference model and an SRAM contents scoreboard.
module tb_sextium_mem_bridge;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RW = 2;
  localparam int WW = 0;
  localparam int TT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] bus_in;
  logic          ack;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] dq_out;
  logic          dq_oe;
  logic [DW-1:0] dq_in;
  logic          ce_n;
  logic          oe_n;
  logic          we_n;
  logic          perr;

  logic [DW-1:0] sram_mem [0:65535];
  logic [DW-1:0] ref_mem [int];
  logic [AW-1:0] pool [16];

  int            n_vec = 0;
  int            n_miss = 0;
  int            cyc = 0;
  int            n_ack = 0;
  int            n_acc = 0;
  logic          prev_ce = 1'b1;
  logic [DW-1:0] exp_bus = '0;
  logic          exp_perr = 1'b0;

  sextium_mem_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .READ_WAIT  (RW),
    .WRITE_WAIT (WW),
    .TURNAROUND (TT)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_mem_read    (rd),
    .i_mem_write   (wr),
    .i_addr_bus    (addr),
    .i_mem_bus_out (wdata),
    .o_mem_bus_in  (bus_in),
    .o_mem_ack     (ack),
    .o_sram_addr   (sram_addr),
    .o_sram_dq_out (dq_out),
    .o_sram_dq_oe  (dq_oe),
    .i_sram_dq_in  (dq_in),
    .o_sram_ce_n   (ce_n),
    .o_sram_oe_n   (oe_n),
    .o_sram_we_n   (we_n),
    .o_proto_err   (perr)
  );

  always #5 clk = ~clk;

  // Async SRAM: data only valid while oe_n is low, write on a strobed edge.
  assign dq_in = (!oe_n) ? sram_mem[sram_addr] : 16'hDEAD;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!ce_n && !we_n) sram_mem[sram_addr] <= dq_out;
    if (ack) n_ack <= n_ack + 1;
    if (prev_ce && !ce_n) n_acc <= n_acc + 1;
    prev_ce <= ce_n;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One core access starting in the current (IDLE) cycle 0; checks every pin
  // through the ACK/TURN timeline and ends at the negedge of the next IDLE cycle.
  task automatic xfer(input bit r, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int hold, output int ack_at);
    int            wt;
    logic [DW-1:0] rd_val;
    logic          e_ce, e_oe, e_we, e_dqoe, e_ack;
    wt     = w ? WW : RW;
    rd_val = (!w && ref_mem.exists(int'(a))) ? ref_mem[int'(a)] : 16'h0;
    if (r && w) exp_perr = 1'b1;
    rd = r; wr = w; addr = a; wdata = d;
    ack_at = -1;
    for (int k = 1; k <= wt + 4 + TT; k++) begin
      @(negedge clk);
      if (k == wt + 4 + hold) begin
        rd = 1'b0; wr = 1'b0; addr = 16'($urandom); wdata = 16'($urandom);
      end
      e_ce   = (k > wt + 3);
      e_oe   = !(!w && k >= 2 && k <= wt + 2);
      e_we   = !(w && k >= 2 && k <= wt + 2);
      e_dqoe = w && (k <= wt + 3);
      e_ack  = (k == wt + 3);
      if (!w && k == wt + 3) exp_bus = rd_val;
      if (ack) ack_at = cyc;
      check_val($sformatf("ce_n k=%0d", k), 32'(ce_n), 32'(e_ce));
      check_val($sformatf("oe_n k=%0d", k), 32'(oe_n), 32'(e_oe));
      check_val($sformatf("we_n k=%0d", k), 32'(we_n), 32'(e_we));
      check_val($sformatf("dq_oe k=%0d", k), 32'(dq_oe), 32'(e_dqoe));
      check_val($sformatf("ack k=%0d", k), 32'(ack), 32'(e_ack));
      check_val($sformatf("bus_in k=%0d", k), 32'(bus_in), 32'(exp_bus));
      check_val($sformatf("sram_addr k=%0d", k), 32'(sram_addr), 32'(a));
      check_val($sformatf("dq_out k=%0d", k), 32'(dq_out), 32'(d));
      check_val($sformatf("proto_err k=%0d", k), 32'(perr), 32'(exp_perr));
    end
    if (w) ref_mem[int'(a)] = d;
    $display("xfer %s addr=0x%04h data=0x%04h ack_cycle=%0d", w ? "WR" : "RD", a,
             w ? d : rd_val, ack_at);
  endtask

  initial begin
    int            ack_at;
    int            prev_ack;
    int            a0;
    int            c0;
    logic [AW-1:0] ra;
    logic [DW-1:0] rdat;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst ack", 32'(ack), 32'd0);
    check_val("rst bus_in", 32'(bus_in), 32'd0);
    check_val("rst sram_addr", 32'(sram_addr), 32'd0);
    check_val("rst dq_out", 32'(dq_out), 32'd0);
    check_val("rst dq_oe", 32'(dq_oe), 32'd0);
    check_val("rst ce_n", 32'(ce_n), 32'd1);
    check_val("rst oe_n", 32'(oe_n), 32'd1);
    check_val("rst we_n", 32'(we_n), 32'd1);
    check_val("rst proto_err", 32'(perr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Prefill known contents through the bridge itself.
    xfer(0, 1, 16'h0123, 16'hBEEF, 0, ack_at);
    xfer(0, 1, 16'h2222, 16'h1111, 0, ack_at);
    for (int i = 0; i < 16; i++) begin
      pool[i] = 16'h1000 + 16'(i * 7);
      xfer(0, 1, pool[i], 16'($urandom), 0, ack_at);
    end

    // Read with wait states, then zero-wait write leaving bus_in alone.
    xfer(1, 0, 16'h0123, 16'h0000, 0, ack_at);
    check_val("read 0x0123 data", 32'(bus_in), 32'h0000BEEF);
    xfer(0, 1, 16'h4000, 16'h5A5A, 0, ack_at);

    // Reset asserted mid-ACCESS of a write.
    rd = 1'b0; wr = 1'b1; addr = 16'h2222; wdata = 16'h7777;
    repeat (2) @(negedge clk);
    check_val("pre-reset we_n", 32'(we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("midrst we_n", 32'(we_n), 32'd1);
    check_val("midrst ce_n", 32'(ce_n), 32'd1);
    check_val("midrst dq_oe", 32'(dq_oe), 32'd0);
    check_val("midrst ack", 32'(ack), 32'd0);
    check_val("midrst bus_in", 32'(bus_in), 32'd0);
    exp_bus = '0;
    wr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("in-reset ack", 32'(ack), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1, 0, 16'h2222, 16'h0000, 0, ack_at);
    check_val("aborted write kept old", 32'(bus_in), 32'h00001111);

    // Request held one cycle past ack: exactly one access and one ack.
    a0 = n_acc; c0 = n_ack;
    xfer(1, 0, pool[3], 16'h0000, 1, ack_at);
    repeat (3) begin
      @(negedge clk);
      check_val("held-req idle ce_n", 32'(ce_n), 32'd1);
    end
    check_val("held-req accesses", 32'(n_acc - a0), 32'd1);
    check_val("held-req acks", 32'(n_ack - c0), 32'd1);

    // Both requests high: write wins, proto_err sticks.
    xfer(1, 1, pool[5], 16'hC3C3, 0, ack_at);
    xfer(1, 0, pool[5], 16'h0000, 0, ack_at);
    check_val("both-high wrote", 32'(bus_in), 32'h0000C3C3);

    // Back-to-back random read/write pairs with ack spacing.
    prev_ack = -1;
    for (int i = 0; i < 12; i++) begin
      ra = pool[$urandom_range(0, 15)];
      xfer(1, 0, ra, 16'($urandom), 0, ack_at);
      if (prev_ack >= 0) check_val("ack spacing rd", 32'(ack_at - prev_ack), 32'(RW + 3 + TT + 1));
      prev_ack = ack_at;
      ra   = pool[$urandom_range(0, 15)];
      rdat = 16'($urandom);
      xfer(0, 1, ra, rdat, 0, ack_at);
      check_val("ack spacing wr", 32'(ack_at - prev_ack), 32'(WW + 3 + TT + 1));
      prev_ack = ack_at;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
